oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014; the address whose CPU write triggers a DMA.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004; the destination address for every DMA write.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cpu_a  input  16  CPU address bus.
REQ-006 cpu_d  input  8  CPU write data.
REQ-007 cpu_rw  input  1  CPU direction: R=1, W=0 (shared `R/`W encoding).
REQ-008 bus_d_in  input  8  read data returned from the system bus.
REQ-009 rdy  output  1  CPU run enable: 1=run, 0=halt.
REQ-010 bus_a  output  16  system bus address.
REQ-011 bus_d_out  output  8  system bus write data.
REQ-012 bus_rw  output  1  system bus direction.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-015 A 1-bit parity flop shall toggle every clk; parity is 0 on the first edge after reset release.
REQ-016 IDLE: a sampled cycle with cpu_a==DMA_REG_ADDR and cpu_rw==W shall load page<=cpu_d and idx<=8'h00, and go to HALT.
REQ-017 HALT: rdy=0; the bus passes the CPU through; stay in HALT while cpu_rw==W (a CPU write in flight); on a cycle with cpu_rw==R, go to ALIGN if parity==1, else to READ.
REQ-018 ALIGN: lasts exactly one cycle; the bus carries the CPU pass-through with rdy=0; then go to READ.
REQ-019 READ: bus_a={page,idx}, bus_rw=R; data_reg<=bus_d_in at the end of the cycle; then go to WRITE.
REQ-020 WRITE: bus_a=OAM_DATA_ADDR, bus_rw=W, bus_d_out=data_reg; idx<=idx+1 (8-bit); if idx==8'hFF, go to IDLE, else go to READ.
REQ-021 In IDLE, HALT and ALIGN: bus_a=cpu_a, bus_rw=cpu_rw, bus_d_out=cpu_d, all combinational with no added latency.
REQ-022 rdy shall be 1 only in IDLE; it goes to 0 in the cycle after the trigger write.
REQ-023 Exactly 256 READ/WRITE pairs per DMA, in ascending source order; idx wraps after 8'hFF with no carry into page.
REQ-024 page==8'hFF shall be legal: the source range is FF00-FFFF.
REQ-025 Trigger writes while busy are ignored; the CPU is halted, so one can arrive only in the HALT write window, and that write is not captured.
REQ-026 rdy-low duration: 1+512 cycles (HALT entered with no CPU write, parity 0), +1 if ALIGN is taken, +1 per extra HALT write cycle.
REQ-027 A trigger write in the same cycle as the final WRITE is not possible because rdy=0; no special case is required.

Reset
REQ-028 While rst_n=0: state=IDLE, rdy=1, busy=0, parity=0, page=0, idx=0, data_reg=0; the bus is in pass-through.
REQ-029 Reset asserted mid-DMA shall abort immediately (asynchronously) with no further DMA bus writes; the CPU resumes under its own reset.

Structure
REQ-030 The `R/`W encoding and the default addresses 16'h4014 and 16'h2004 shall live in the shared defines header (k6502_defs).
REQ-031 The state encoding shall be a local 3-bit constant set private to oam_dma.
REQ-032 One combinational sub-module, dma_bus_mux, shall select between the CPU pass-through and the DMA-driven bus_a/bus_rw/bus_d_out.
REQ-033 The FSM, parity flop, page, idx and data_reg shall remain in oam_dma.

Verification
REQ-034 Trigger a write of 8'h02 to 4014 with parity 0 and no trailing CPU write -> rdy low for 513 cycles; reads 0200..02FF alternate with writes to 2004; the OAM model holds the source image.
REQ-035 Same trigger with parity 1 at HALT exit -> exactly one ALIGN cycle; rdy low for 514 cycles; data order unchanged.
REQ-036 Hold cpu_rw==W for 2 cycles after the trigger (JSR-style push) -> HALT lasts 3 cycles; the first DMA read of 0200 occurs only after cpu_rw returns to R.
REQ-037 Trigger with page 8'hFF -> the last read is at FFFF and idx wraps to 00; after 256 writes rdy=1, busy=0, and page is not modified.
REQ-038 Pulse rst_n low at the 100th DMA cycle -> rdy=1 and busy=0 immediately (asynchronously); no write to 2004 after reset; a new trigger afterwards yields a full 256-byte transfer.
REQ-039 Write to 4015 or read from 4014 -> no DMA starts, rdy stays 1, and the bus is in pass-through.

Source files
------------

// File: rtl/k6502_defs.sv
// Shared 6502-system constants: bus direction encoding and fixed I/O addresses.
package k6502_defs;

    localparam logic RW_R = 1'b1;
    localparam logic RW_W = 1'b0;

    localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

    typedef enum logic [1:0] {
        SEL_CPU   = 2'd0,
        SEL_READ  = 2'd1,
        SEL_WRITE = 2'd2
    } bus_sel_e;

endpackage

// File: rtl/dma_bus_mux.sv
// System bus source select: CPU pass-through or DMA read/write cycle.
module dma_bus_mux
    import k6502_defs::*;
#(
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
    input  bus_sel_e    sel,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_rw,
    input  logic [15:0] src_a,
    input  logic [7:0]  wr_d,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d_out,
    output logic        bus_rw
);

    always_comb begin
        bus_a     = cpu_a;
        bus_d_out = cpu_d;
        bus_rw    = cpu_rw;
        unique case (sel)
            SEL_READ: begin
                bus_a  = src_a;
                bus_rw = RW_R;
            end
            SEL_WRITE: begin
                bus_a     = OAM_DATA_ADDR;
                bus_rw    = RW_W;
                bus_d_out = wr_d;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/oam_dma.sv
// Sprite OAM DMA: halts the CPU and copies a 256-byte page to the OAM data port.
module oam_dma
    import k6502_defs::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_d_in,
    output logic        rdy,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d_out,
    output logic        bus_rw,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic       parity_q;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    bus_sel_e   sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            page_q   <= 8'h00;
            idx_q    <= 8'h00;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            parity_q <= ~parity_q;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        sel     = SEL_CPU;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_a == DMA_REG_ADDR && cpu_rw == RW_W) begin
                    page_d  = cpu_d;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // Wait out any CPU write, then align reads to even cycles.
                if (cpu_rw == RW_R)
                    state_d = parity_q ? S_ALIGN : S_READ;
            end
            S_ALIGN: state_d = S_READ;
            S_READ: begin
                sel     = SEL_READ;
                data_d  = bus_d_in;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                sel     = SEL_WRITE;
                idx_d   = idx_q + 8'h01;
                state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rdy  = (state_q == S_IDLE);
    assign busy = (state_q != S_IDLE);

    dma_bus_mux #(
        .OAM_DATA_ADDR(OAM_DATA_ADDR)
    ) u_mux (
        .sel      (sel),
        .cpu_a    (cpu_a),
        .cpu_d    (cpu_d),
        .cpu_rw   (cpu_rw),
        .src_a    ({page_q, idx_q}),
        .wr_d     (data_q),
        .bus_a    (bus_a),
        .bus_d_out(bus_d_out),
        .bus_rw   (bus_rw)
    );

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: pass-through vectors plus modelled DMA transfers.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_rw;
    logic [7:0]  bus_d_in;
    logic        rdy;
    logic [15:0] bus_a;
    logic [7:0]  bus_d_out;
    logic        bus_rw;
    logic        busy;

    logic [7:0] mem [0:65535];
    logic [7:0] oam_q [$];
    int         edges;
    int         n_chk = 0;
    int         n_fail = 0;

    oam_dma dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_a    (cpu_a),
        .cpu_d    (cpu_d),
        .cpu_rw   (cpu_rw),
        .bus_d_in (bus_d_in),
        .rdy      (rdy),
        .bus_a    (bus_a),
        .bus_d_out(bus_d_out),
        .bus_rw   (bus_rw),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign bus_d_in = mem[bus_a];

    // Parity model: number of rising edges since reset release, mod 2.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    // OAM model: every bus write to the OAM data port appends a byte.
    always @(negedge clk)
        if (rst_n === 1'b1 && bus_rw === 1'b0 && bus_a === 16'h2004)
            oam_q.push_back(bus_d_out);

    task automatic check(input string name, input logic [39:0] act,
                         input logic [39:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle until the HALT exit of a trigger issued now has the wanted parity.
    task automatic prep(input int nwr, input int want);
        for (int i = 0; i < 4; i++)
            if (((edges + 1 + nwr) % 2) != want) step();
    endtask

    task automatic run_dma(input logic [7:0] page, input int nwr,
                           input bit trick, input int abort_at);
        int k, pre, lowcnt, bad, first_bad, align, j, mism;
        bit er, done;
        logic [15:0] src;
        oam_q.delete();
        cpu_a  = 16'h4014;
        cpu_rw = 1'b0;
        cpu_d  = page;
        @(negedge clk);
        check("trigger_rdy", {rdy, busy}, 2'b10);
        step();
        pre = -1; lowcnt = 0; bad = 0; first_bad = -1; done = 0; align = 0;
        for (k = 0; k < 1200 && !done; k++) begin
            if (k < nwr) begin
                cpu_rw = 1'b0;
                cpu_a  = (trick && k == 0) ? 16'h4014 : 16'h01FD - 16'(k);
                cpu_d  = 8'($urandom);
            end else begin
                cpu_rw = 1'b1;
                cpu_a  = 16'($urandom);
                cpu_d  = 8'($urandom);
            end
            if (k == nwr) begin
                align = edges % 2;
                pre   = nwr + 1 + align;
            end
            if (abort_at >= 0 && pre >= 0 && k == pre + abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                check("abort_rdy_busy", {rdy, busy}, 2'b10);
                check("abort_pass", {bus_a, bus_rw, bus_d_out},
                      {cpu_a, cpu_rw, cpu_d});
                repeat (3) step();
                check("abort_writes", oam_q.size(), abort_at / 2);
                rst_n = 1'b1;
                repeat (4) step();
                check("abort_no_more", oam_q.size(), abort_at / 2);
                check("abort_idle", {rdy, busy}, 2'b10);
                return;
            end
            @(negedge clk);
            er = (pre >= 0 && k >= pre + 512);
            if (rdy !== er || busy !== !er) bad++;
            if (rdy === 1'b0) lowcnt++;
            if (pre < 0 || k < pre || k >= pre + 512) begin
                if (bus_a !== cpu_a || bus_rw !== cpu_rw || bus_d_out !== cpu_d)
                    bad++;
                if (pre >= 0 && k >= pre + 512) done = 1;
            end else begin
                j   = k - pre;
                src = {page, 8'(j / 2)};
                if (j % 2 == 0) begin
                    if (bus_a !== src || bus_rw !== 1'b1) bad++;
                end else begin
                    if (bus_a !== 16'h2004 || bus_rw !== 1'b0 ||
                        bus_d_out !== mem[src]) bad++;
                end
            end
            if (bad != 0 && first_bad < 0) first_bad = k;
            step();
        end
        cpu_rw = 1'b1;
        cpu_a  = 16'h8000;
        if (first_bad >= 0)
            $display("page %h: first deviation at cycle %0d", page, first_bad);
        check("dma_done", done, 1'b1);
        check("bus_sequence_errs", bad, 0);
        check("rdy_low_cycles", lowcnt, pre + 512);
        check("oam_count", oam_q.size(), 256);
        mism = 0;
        for (int i = 0; i < 256 && i < oam_q.size(); i++)
            if (oam_q[i] !== mem[{page, 8'(i)}]) mism++;
        check("oam_image", mism, 0);
    endtask

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        logic        exp_rdy;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{16'h4015, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[1] = '{16'h4014, 1'b1, 8'h03, 1'b1, 1'b0};
        vecs[2] = '{16'h4013, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[3] = '{16'h2004, 1'b0, 8'h5A, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 1'b0, 8'h14, 1'b1, 1'b0};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        rst_n  = 1'b0;
        cpu_a  = 16'h4014;
        cpu_rw = 1'b0;
        cpu_d  = 8'h07;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdy_busy", {rdy, busy}, 2'b10);
        check("reset_pass", {bus_a, bus_rw, bus_d_out}, {16'h4014, 1'b0, 8'h07});
        @(posedge clk);
        #1;
        cpu_rw = 1'b1;
        cpu_a  = 16'h8000;
        rst_n  = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            cpu_a  = vecs[i].a;
            cpu_rw = vecs[i].rw;
            cpu_d  = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d_bus", i),
                  {bus_a, bus_rw, bus_d_out, rdy, busy},
                  {vecs[i].a, vecs[i].rw, vecs[i].d,
                   vecs[i].exp_rdy, vecs[i].exp_busy});
            step();
            cpu_rw = 1'b1;
            cpu_a  = 16'h8000;
            @(negedge clk);
            check($sformatf("vec%0d_after", i), {rdy, busy}, 2'b10);
            step();
        end

        prep(0, 0);
        run_dma(8'h02, 0, 1'b0, -1);
        prep(0, 1);
        run_dma(8'h02, 0, 1'b0, -1);
        prep(2, 0);
        run_dma(8'h02, 2, 1'b1, -1);
        prep(0, 0);
        run_dma(8'hFF, 0, 1'b0, -1);
        run_dma(8'h02, 0, 1'b0, 100);
        run_dma(8'h02, 0, 1'b0, -1);

        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 3)) step();
            run_dma(8'($urandom), int'($urandom_range(0, 2)), r[0], -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
